// File: rtl/prefetch_queue_pkg.sv
// Shared definitions for the prefetch_queue slice: fetch FSM states and
// byte-offset sizing derived from the memory word width.
package prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ABORT = 2'd2
  } fetch_state_e;

  function automatic int off_width(input int bus_bytes);
    return $clog2(bus_bytes);
  endfunction

endpackage

// File: rtl/prefetch_queue_if.sv
// Single-outstanding memory read port between the prefetcher (master) and
// the bus interface unit (slave).
interface prefetch_queue_if
  import prefetch_pkg::*;
#(
  parameter int BUS_BYTES = 2
);
  localparam int AW = 20 - off_width(BUS_BYTES);

  logic                   mem_access;
  logic [AW-1:0]          mem_address;
  logic                   mem_ack;
  logic [8*BUS_BYTES-1:0] mem_data;

  modport master (
    output mem_access,
    output mem_address,
    input  mem_ack,
    input  mem_data
  );

  modport slave (
    input  mem_access,
    input  mem_address,
    output mem_ack,
    output mem_data
  );
endinterface

// File: rtl/prefetch_queue_byte_queue.sv
// Circular byte FIFO with a multi-byte write port, 1-or-2-byte pop and a
// synchronous flush. The second read port exists only with PREFETCH_DUAL_READ_EN.
module byte_queue
  import prefetch_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int BUS_BYTES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush_i,
  input  logic [8*BUS_BYTES-1:0]        wr_data_i,
  input  logic [off_width(BUS_BYTES):0] wr_cnt_i,
  input  logic [1:0]                    pop_cnt_i,
  output logic [7:0]                    rd_data0_o,
`ifdef PREFETCH_DUAL_READ_EN
  output logic [7:0]                    rd_data1_o,
`endif
  output logic [$clog2(DEPTH):0]        count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      for (int i = 0; i < BUS_BYTES; i++) begin
        if (i < int'(wr_cnt_i)) mem_q[tail_q + PW'(i)] <= wr_data_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PW'(pop_cnt_i);
      tail_q  <= tail_q + PW'(wr_cnt_i);
      count_q <= count_q + CW'(wr_cnt_i) - CW'(pop_cnt_i);
    end
  end

  assign rd_data0_o = mem_q[head_q];
`ifdef PREFETCH_DUAL_READ_EN
  assign rd_data1_o = mem_q[head_q + PW'(1)];
`endif
  assign count_o = count_q;

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetcher: fetches aligned words from CS:IP and feeds a byte
// queue for the decoder. PREFETCH_DUAL_READ_EN adds a two-byte read port.
//
// state | meaning
// IDLE  | no request outstanding; issues one when not stalled and space allows
// FETCH | request outstanding; data on ack is written to the queue
// ABORT | request outstanding after a redirect; data on ack is dropped
module prefetch_queue
  import prefetch_pkg::*;
#(
  parameter int BUS_BYTES = 2,
  parameter int DEPTH     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            new_cs,
  input  logic [15:0]            new_ip,
  input  logic                   load_new_ip,
  input  logic                   stall,
  prefetch_queue_if.master       mem,
  output logic                   q_valid,
  output logic [7:0]             q_data,
  output logic [15:0]            q_ip,
  input  logic                   q_rd_en,
`ifdef PREFETCH_DUAL_READ_EN
  output logic                   q_valid1,
  output logic [7:0]             q_data1,
  input  logic                   q_rd2_en,
`endif
  output logic [$clog2(DEPTH):0] q_count
);
  localparam int OW  = off_width(BUS_BYTES);
  localparam int AW  = 20 - OW;
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int WCW = OW + 1;

  fetch_state_e   state_q;
  logic [15:0]    cs_q;
  logic [15:0]    fetch_ip_q;
  logic [AW-1:0]  req_addr_q;
  logic [OW-1:0]  req_off_q;
  logic           mem_access_q;

  logic [CW-1:0]  count;
  logic [AW-1:0]  word_addr;
  logic [OW-1:0]  off;
  logic [WCW-1:0] need;
  logic [CW-1:0]  free;
  logic           issue;
  logic           wr_en;
  logic [WCW-1:0] wr_cnt;
  logic [1:0]     pop_cnt;
  logic [8*BUS_BYTES-1:0] wr_data;

  // The CS base is 16-byte aligned, so its low bits never carry into the word address.
  assign word_addr = {cs_q, {(4-OW){1'b0}}} + AW'(fetch_ip_q[15:OW]);
  assign off       = fetch_ip_q[OW-1:0];
  assign need      = WCW'(BUS_BYTES) - WCW'(off);
  assign free      = CW'(DEPTH) - count;
  assign issue     = !stall && !load_new_ip && (free >= CW'(need));

  assign wr_en   = (state_q == FETCH) && mem.mem_ack && !load_new_ip;
  assign wr_cnt  = wr_en ? (WCW'(BUS_BYTES) - WCW'(req_off_q)) : '0;
  assign wr_data = mem.mem_data >> {req_off_q, 3'b000};

`ifdef PREFETCH_DUAL_READ_EN
  assign pop_cnt = (q_rd2_en && count >= CW'(2)) ? 2'd2 :
                   (q_rd_en && count != '0)      ? 2'd1 : 2'd0;
`else
  assign pop_cnt = {1'b0, q_rd_en && (count != '0)};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cs_q         <= '0;
      fetch_ip_q   <= '0;
      req_addr_q   <= '0;
      req_off_q    <= '0;
      mem_access_q <= 1'b0;
    end else begin
      if (load_new_ip) begin
        cs_q       <= new_cs;
        fetch_ip_q <= new_ip;
      end else if (wr_en) begin
        fetch_ip_q <= fetch_ip_q + 16'(BUS_BYTES) - 16'(req_off_q);
      end

      unique case (state_q)
        IDLE: begin
          if (issue) begin
            state_q      <= FETCH;
            mem_access_q <= 1'b1;
            req_addr_q   <= word_addr;
            req_off_q    <= off;
          end
        end
        FETCH: begin
          if (mem.mem_ack) begin
            state_q      <= IDLE;
            mem_access_q <= 1'b0;
          end else if (load_new_ip) begin
            state_q <= ABORT;
          end
        end
        ABORT: begin
          // An ack always ends the bus cycle, even with a fresh redirect.
          if (mem.mem_ack) begin
            state_q      <= IDLE;
            mem_access_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          mem_access_q <= 1'b0;
        end
      endcase
    end
  end

  byte_queue #(
    .DEPTH     (DEPTH),
    .BUS_BYTES (BUS_BYTES)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (load_new_ip),
    .wr_data_i  (wr_data),
    .wr_cnt_i   (wr_cnt),
    .pop_cnt_i  (pop_cnt),
    .rd_data0_o (q_data),
`ifdef PREFETCH_DUAL_READ_EN
    .rd_data1_o (q_data1),
`endif
    .count_o    (count)
  );

  assign mem.mem_access  = mem_access_q;
  assign mem.mem_address = req_addr_q;
  assign q_count         = count;
  assign q_valid         = (count != '0);
  assign q_ip            = fetch_ip_q - 16'(count);
`ifdef PREFETCH_DUAL_READ_EN
  assign q_valid1        = (count >= CW'(2));
`endif

endmodule

// File: doc/prefetch_queue.md
# prefetch_queue

Parametrised instruction prefetcher with an integrated byte queue. It fetches aligned words of BUS_BYTES bytes from CS:IP over a single-outstanding memory port and unpacks the useful bytes into an internal DEPTH-byte queue in one cycle. The decoder reads bytes, and each byte carries its IP. The block sits between the bus interface unit and the instruction decoder, and supports redirect with flush and in-flight abort, an external fetch stall, and an optional two-byte read port.

## Interface
Parameters:
- BUS_BYTES, 2, memory word width in bytes; legal values 2 and 4.
- DEPTH, 8, queue capacity in bytes; power of two, at least 2*BUS_BYTES.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- new_cs  in  16  code segment for redirect.
- new_ip  in  16  instruction pointer for redirect.
- load_new_ip  in  1  redirect strobe: flush the queue and load CS:IP.
- stall  in  1  inhibit issuing new fetches; an in-flight fetch still completes.
- mem_access  out  1  request valid; held until mem_ack.
- mem_ack  in  1  single-cycle completion pulse; mem_data is valid in the same cycle.
- mem_address  out  20-log2(BUS_BYTES)  word address; stable while mem_access is high.
- mem_data  in  8*BUS_BYTES  read data, little-endian byte lanes.
- q_valid  out  1  queue is non-empty.
- q_data  out  8  head byte.
- q_ip  out  16  IP of the head byte.
- q_rd_en  in  1  pop one byte; ignored when q_valid is 0.
- q_count  out  log2(DEPTH)+1  bytes currently held.

## Operation
- Registered state: cs, fetch_ip (IP of the next byte to fetch), state, req_addr, req_off, and the queue.
- Linear address = {cs,4'b0} + fetch_ip, 20-bit, wrapping mod 2^20. Word address = linear >> log2(BUS_BYTES). Byte offset off = fetch_ip[log2(BUS_BYTES)-1:0].
- Because the CS base is 16-byte aligned, a word never straddles the 64 KiB IP wrap. fetch_ip advances by BUS_BYTES-off and wraps mod 2^16.
- The FSM has three states: IDLE, FETCH, ABORT.
  - IDLE→FETCH when !stall && !load_new_ip && free space ≥ BUS_BYTES-off, where free space is DEPTH-q_count. On this transition, req_addr and req_off are latched.
  - FETCH→IDLE on mem_ack. Bytes at lanes req_off..BUS_BYTES-1 are written to the queue in ascending order and fetch_ip advances.
  - FETCH→ABORT on load_new_ip without mem_ack.
  - ABORT→IDLE on mem_ack, with the data discarded.
  - load_new_ip in ABORT stays in ABORT and reloads CS:IP.
- mem_access = (state==FETCH || state==ABORT). mem_address = req_addr; both are registered outputs.
- Redirect (load_new_ip) sets q_count to 0 and loads cs ← new_cs and fetch_ip ← new_ip, in every state.
  - If mem_ack arrives in the same cycle while in FETCH, the data is discarded and the FSM goes to IDLE.
  - A redirect takes priority over q_rd_en in the same cycle.
- Pop and write may occur in the same cycle: q_count ← q_count - pop + written. The space check uses q_count before the pop.
- q_ip = fetch_ip - q_count, mod 2^16.
- Reset values: state IDLE, cs 0, fetch_ip 0, mem_access 0, mem_address 0, q_count 0, q_valid 0, q_ip 0. The queue data contents are undefined.
- Reset asserted mid-request drops mem_access asynchronously. The bus side is also reset, so no pending ack is expected.

## Timing
- mem_access rises the cycle after the IDLE decision. mem_ack may arrive at the earliest one cycle after mem_access rises.
- Written bytes appear at q_valid/q_data on the edge after mem_ack.
- There is at least one IDLE cycle between requests, so peak throughput is BUS_BYTES bytes every 3 cycles with a 1-cycle ack.
- Redirect-to-first-request latency is 1 cycle from IDLE. From FETCH it is 1 cycle after the aborted ack.
- q_valid, q_data and q_ip are registered, or decoded from registers only, with no combinational path from mem_ack.

## Configuration
- PREFETCH_DUAL_READ_EN:
  - Defined: adds outputs q_valid1 (q_count ≥ 2) and q_data1 (the byte after head), plus input q_rd2_en, which pops two bytes when q_valid1 is set; q_rd2_en takes precedence over q_rd_en.
  - Undefined: these ports do not exist and the pop is at most one byte per cycle.

## Structure
- Package prefetch_pkg holds the state enum (IDLE/FETCH/ABORT) and a function that computes the byte offset width from BUS_BYTES.
- Sub-module byte_queue: a DEPTH-entry circular register FIFO with a multi-byte write port (up to BUS_BYTES bytes plus a count), a 1-or-2-byte pop port and a synchronous flush. Head/tail wrap is mod DEPTH.

## Test plan
- Reset, then load CS=0x1000, IP=0x0003, BUS_BYTES=2, memory returning the byte value (addr&0xFF): the first request is to word address 0x08001, and the queue yields 0x03, 0x04, 0x05 with q_ip 0x0003, 0x0004, 0x0005.
- No pops until full, DEPTH=8: fetching stops at q_count 8 and mem_access stays low. One pop followed by a second pop then triggers the next request.
- IP=0xFFFE, CS=0: fetches 0xFFFE–0xFFFF, then word address 0x00000. q_ip wraps to 0x0000.
- Redirect while mem_access is held with ack delayed 4 cycles: mem_address is unchanged and the acked data is discarded. The next request targets the new CS:IP, and q_count is 0 on the cycle after the redirect.
- Redirect coincident with mem_ack and q_rd_en: nothing is written, q_count becomes 0, and q_ip becomes new_ip.
- With PREFETCH_DUAL_READ_EN and BUS_BYTES=4: q_rd2_en pops two bytes per cycle while 4 bytes arrive per ack. q_count never exceeds DEPTH and the byte order is preserved.
